// File: rtl/pipe_loopback_phy.sv
// Behavioural PIPE PHY loopback: MAC TX -> MAC RX with per-lane latency/skew,
// PhyStatus handshakes for receiver detect, rate and power-down, and error injection.
module pipe_loopback_phy #(
    parameter int unsigned LANESNUMBER    = 16,
    parameter int unsigned MAXPIPEWIDTH   = 32,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned MAX_SKEW       = 3,
    parameter int unsigned DETECT_DELAY   = 4,
    parameter int unsigned RATE_DELAY     = 6,
    parameter int unsigned PD_DELAY       = 3,
    parameter int unsigned STARTUP_CYCLES = 8
) (
    input  logic                                    CLK,
    input  logic                                    reset,
    input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     TxData,
    input  logic [LANESNUMBER-1:0]                  TxDataValid,
    input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
    input  logic [LANESNUMBER-1:0]                  TxElecIdle,
    input  logic [LANESNUMBER-1:0]                  TxStartBlock,
    input  logic [2*LANESNUMBER-1:0]                TxSyncHeader,
    input  logic [LANESNUMBER-1:0]                  TxDetectRx_Loopback,
    input  logic [4*LANESNUMBER-1:0]                PowerDown,
    input  logic [3:0]                              Rate,
    input  logic [LANESNUMBER-1:0]                  RxPresent,
    input  logic [2*LANESNUMBER-1:0]                LaneSkew,
    input  logic [LANESNUMBER-1:0]                  ErrInject,
    output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]     RxData,
    output logic [LANESNUMBER-1:0]                  RxDataValid,
    output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
    output logic [LANESNUMBER-1:0]                  RxStartBlock,
    output logic [2*LANESNUMBER-1:0]                RxSyncHeader,
    output logic [LANESNUMBER-1:0]                  RxValid,
    output logic [3*LANESNUMBER-1:0]                RxStatus,
    output logic [LANESNUMBER-1:0]                  RxElectricalIdle,
    output logic [LANESNUMBER-1:0]                  PhyStatus
);

    localparam int unsigned KW    = MAXPIPEWIDTH / 8;
    localparam int unsigned DEPTH = LATENCY + MAX_SKEW;
    localparam int unsigned TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StStatus} evState_t;
    typedef enum logic [1:0] {CauseRate, CauseDet, CausePd} evCause_t;

    logic [15:0] startCnt;
    logic        startup;

    always_ff @(posedge CLK) begin
        if (reset) begin
            startCnt <= 16'(STARTUP_CYCLES);
        end else if (startCnt != 16'd0) begin
            startCnt <= startCnt - 16'd1;
        end
    end

    assign startup = (startCnt != 16'd0);

    for (genvar i = 0; i < LANESNUMBER; i++) begin : gLane
        logic [MAXPIPEWIDTH-1:0] dataLine  [DEPTH];
        logic [KW-1:0]           kLine     [DEPTH];
        logic                    validLine [DEPTH];
        logic                    startLine [DEPTH];
        logic [1:0]              syncLine  [DEPTH];
        logic                    idleLine  [DEPTH];
        logic [1:0]              skew;
        logic [TW-1:0]           tap;
        logic [MAXPIPEWIDTH-1:0] inData;
        logic                    outIdle;

        assign inData = TxData[i*MAXPIPEWIDTH +: MAXPIPEWIDTH]
                      ^ {{(MAXPIPEWIDTH-1){1'b0}}, ErrInject[i] & TxDataValid[i]};

        always_ff @(posedge CLK) begin
            if (reset) begin
                skew <= (32'(LaneSkew[2*i +: 2]) > MAX_SKEW) ? 2'(MAX_SKEW)
                                                             : LaneSkew[2*i +: 2];
                for (int s = 0; s < DEPTH; s++) begin
                    dataLine[s]  <= '0;
                    kLine[s]     <= '0;
                    validLine[s] <= 1'b0;
                    startLine[s] <= 1'b0;
                    syncLine[s]  <= 2'b00;
                    idleLine[s]  <= 1'b1;
                end
            end else begin
                dataLine[0]  <= inData;
                kLine[0]     <= TxDataK[i*KW +: KW];
                validLine[0] <= TxDataValid[i];
                startLine[0] <= TxStartBlock[i];
                syncLine[0]  <= TxSyncHeader[2*i +: 2];
                idleLine[0]  <= TxElecIdle[i];
                for (int s = 1; s < DEPTH; s++) begin
                    dataLine[s]  <= dataLine[s-1];
                    kLine[s]     <= kLine[s-1];
                    validLine[s] <= validLine[s-1];
                    startLine[s] <= startLine[s-1];
                    syncLine[s]  <= syncLine[s-1];
                    idleLine[s]  <= idleLine[s-1];
                end
            end
        end

        // Stage 0 already holds one cycle of delay, so D cycles lands on stage D-1.
        assign tap     = TW'(LATENCY - 1) + TW'(skew);
        assign outIdle = reset | idleLine[tap];

        assign RxData[i*MAXPIPEWIDTH +: MAXPIPEWIDTH] = outIdle ? '0 : dataLine[tap];
        assign RxDataK[i*KW +: KW]                    = outIdle ? '0 : kLine[tap];
        assign RxStartBlock[i]                        = ~outIdle & startLine[tap];
        assign RxSyncHeader[2*i +: 2]                 = outIdle ? 2'b00 : syncLine[tap];
        assign RxDataValid[i]                         = ~reset & validLine[tap];
        assign RxValid[i]                             = ~outIdle & validLine[tap];
        assign RxElectricalIdle[i]                    = outIdle;

        evState_t    state;
        evCause_t    cause;
        evCause_t    trigCause;
        logic [15:0] cnt;
        logic [15:0] trigDelay;
        logic [3:0]  rateShadow;
        logic [3:0]  pdShadow;
        logic [2:0]  evRxStatus;
        logic        detPrev;
        logic        ratePend;
        logic        pdPend;
        logic        evStatus;
        logic        detEdge;
        logic        rateReq;
        logic        pdReq;
        logic        trig;

        assign detEdge = TxDetectRx_Loopback[i] & ~detPrev & TxElecIdle[i];
        assign rateReq = (Rate != rateShadow) | ratePend;
        assign pdReq   = (PowerDown[4*i +: 4] != pdShadow) | pdPend;

        always_comb begin
            trig      = rateReq | detEdge | pdReq;
            trigCause = CauseRate;
            trigDelay = 16'(RATE_DELAY);
            if (!rateReq && detEdge) begin
                trigCause = CauseDet;
                trigDelay = 16'(DETECT_DELAY);
            end else if (!rateReq && pdReq) begin
                trigCause = CausePd;
                trigDelay = 16'(PD_DELAY);
            end
        end

        always_ff @(posedge CLK) begin
            if (reset) begin
                state      <= StIdle;
                cause      <= CauseRate;
                cnt        <= 16'd0;
                rateShadow <= Rate;
                pdShadow   <= PowerDown[4*i +: 4];
                detPrev    <= TxDetectRx_Loopback[i];
                ratePend   <= 1'b0;
                pdPend     <= 1'b0;
                evStatus   <= 1'b0;
                evRxStatus <= 3'b000;
            end else begin
                detPrev    <= TxDetectRx_Loopback[i];
                evStatus   <= 1'b0;
                evRxStatus <= 3'b000;
                unique case (state)
                    StIdle: begin
                        if (trig) begin
                            cause <= trigCause;
                            cnt   <= trigDelay;
                            if (trigCause == CauseRate) begin
                                rateShadow <= Rate;
                                ratePend   <= 1'b0;
                            end else if (trigCause == CausePd) begin
                                pdShadow <= PowerDown[4*i +: 4];
                                pdPend   <= 1'b0;
                            end
                            if (trigDelay <= 16'd1) begin
                                state      <= StStatus;
                                evStatus   <= 1'b1;
                                evRxStatus <= (trigCause == CauseDet && RxPresent[i]) ? 3'b011
                                                                                      : 3'b000;
                            end else begin
                                state <= StWait;
                            end
                        end
                    end
                    StWait: begin
                        cnt <= cnt - 16'd1;
                        // Leaving on count 2 puts the pulse exactly N cycles after the trigger.
                        if (cnt <= 16'd2) begin
                            state      <= StStatus;
                            evStatus   <= 1'b1;
                            evRxStatus <= (cause == CauseDet && RxPresent[i]) ? 3'b011 : 3'b000;
                        end
                    end
                    StStatus: state <= StIdle;
                    default:  state <= StIdle;
                endcase
                if (state != StIdle) begin
                    if (Rate != rateShadow) ratePend <= 1'b1;
                    if (PowerDown[4*i +: 4] != pdShadow) pdPend <= 1'b1;
                end
            end
        end

        assign PhyStatus[i]       = reset | startup | evStatus;
        assign RxStatus[3*i +: 3] = reset ? 3'b000 : evRxStatus;
    end

endmodule

// File: tb/tb_pipe_loopback_phy.sv
// Self-checking bench for pipe_loopback_phy: startup, detect, skewed datapath with
// a scoreboard, error injection, rate/detect collision, reset mid-WAIT and pending PD.
module tb_pipe_loopback_phy;

    localparam int L  = 16;
    localparam int W  = 32;
    localparam int KW = 4;

    logic              CLK;
    logic              reset;
    logic [W*L-1:0]    TxData;
    logic [L-1:0]      TxDataValid;
    logic [KW*L-1:0]   TxDataK;
    logic [L-1:0]      TxElecIdle;
    logic [L-1:0]      TxStartBlock;
    logic [2*L-1:0]    TxSyncHeader;
    logic [L-1:0]      TxDetectRx_Loopback;
    logic [4*L-1:0]    PowerDown;
    logic [3:0]        Rate;
    logic [L-1:0]      RxPresent;
    logic [2*L-1:0]    LaneSkew;
    logic [L-1:0]      ErrInject;
    logic [W*L-1:0]    RxData;
    logic [L-1:0]      RxDataValid;
    logic [KW*L-1:0]   RxDataK;
    logic [L-1:0]      RxStartBlock;
    logic [2*L-1:0]    RxSyncHeader;
    logic [L-1:0]      RxValid;
    logic [3*L-1:0]    RxStatus;
    logic [L-1:0]      RxElectricalIdle;
    logic [L-1:0]      PhyStatus;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;

    typedef struct {
        int          due;
        int          lane;
        logic [41:0] exp;
    } sbEntry_t;

    sbEntry_t sb[$];

    localparam logic [L-1:0] PRESENT = 16'h00FF;

    pipe_loopback_phy dut (
        .CLK                 (CLK),
        .reset               (reset),
        .TxData              (TxData),
        .TxDataValid         (TxDataValid),
        .TxDataK             (TxDataK),
        .TxElecIdle          (TxElecIdle),
        .TxStartBlock        (TxStartBlock),
        .TxSyncHeader        (TxSyncHeader),
        .TxDetectRx_Loopback (TxDetectRx_Loopback),
        .PowerDown           (PowerDown),
        .Rate                (Rate),
        .RxPresent           (RxPresent),
        .LaneSkew            (LaneSkew),
        .ErrInject           (ErrInject),
        .RxData              (RxData),
        .RxDataValid         (RxDataValid),
        .RxDataK             (RxDataK),
        .RxStartBlock        (RxStartBlock),
        .RxSyncHeader        (RxSyncHeader),
        .RxValid             (RxValid),
        .RxStatus            (RxStatus),
        .RxElectricalIdle    (RxElectricalIdle),
        .PhyStatus           (PhyStatus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic nextCycle();
        @(negedge CLK);
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            #1;
            nChecks++;
            if (PhyStatus !== '1 || RxElectricalIdle !== '1 || RxData !== '0 ||
                RxValid !== '0 || RxDataValid !== '0 || RxStatus !== '0) begin
                nFails++;
                $display("FAIL reset_outputs cyc=%0d PhyStatus=%h ElecIdle=%h RxValid=%h RxStatus=%h required ffff/ffff/0000/0",
                         cyc, PhyStatus, RxElectricalIdle, RxValid, RxStatus);
            end
        end
        for (int k = 0; k < 10; k++) begin
            nextCycle();
            reset = 1'b0;
            #1;
            nChecks++;
            if (PhyStatus !== ((k < 8) ? 16'hFFFF : 16'h0000) || RxElectricalIdle !== 16'hFFFF) begin
                nFails++;
                $display("FAIL startup k=%0d PhyStatus=%h ElecIdle=%h required %h/ffff",
                         k, PhyStatus, RxElectricalIdle, (k < 8) ? 16'hFFFF : 16'h0000);
            end
        end
    endtask

    task automatic test_detect();
        logic [3*L-1:0] expSt;
        logic [L-1:0]   expPhy;
        logic [3*L-1:0] expRx;
        for (int l = 0; l < L; l++) expSt[3*l +: 3] = PRESENT[l] ? 3'b011 : 3'b000;
        nextCycle();
        TxDetectRx_Loopback = '1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) nextCycle();
            #1;
            expPhy = (k == 4) ? 16'hFFFF : 16'h0000;
            expRx  = (k == 4) ? expSt : '0;
            nChecks++;
            if (PhyStatus !== expPhy || RxStatus !== expRx) begin
                nFails++;
                $display("FAIL detect k=%0d PhyStatus=%h RxStatus=%h required %h/%h",
                         k, PhyStatus, RxStatus, expPhy, expRx);
            end
        end
        TxDetectRx_Loopback = '0;
    endtask

    task automatic test_datapath();
        logic [W-1:0]  d;
        logic [W-1:0]  ed;
        logic [KW-1:0] kk;
        logic [1:0]    sh;
        logic          v;
        logic          idl;
        logic          er;
        logic          stb;
        logic [41:0]   obs;
        sbEntry_t      e;
        int            dly;
        for (int c = 0; c < 18; c++) begin
            nextCycle();
            if (c < 12) begin
                for (int l = 0; l < L; l++) begin
                    v   = (c % 4) != 3;
                    idl = (c == 5) || (c == 9);
                    er  = (l == 2) && (c == 2 || c == 3);
                    d   = $urandom;
                    if (l == 0 && c == 0) d = 32'hA5A5A5A5;
                    if (l == 2 && (c == 2 || c == 3)) d = 32'h00000010;
                    kk  = 4'($urandom_range(0, 15));
                    sh  = 2'($urandom_range(0, 3));
                    stb = 1'($urandom_range(0, 1));
                    TxData[l*W +: W]        = d;
                    TxDataK[l*KW +: KW]     = kk;
                    TxDataValid[l]          = v;
                    TxElecIdle[l]           = idl;
                    TxStartBlock[l]         = stb;
                    TxSyncHeader[2*l +: 2]  = sh;
                    ErrInject[l]            = er;
                    if (l < 4) begin
                        dly   = 2 + ((l == 1) ? 3 : (l == 3) ? 2 : 0);
                        ed    = idl ? 32'h0 : (d ^ {31'b0, er & v});
                        e.due = cyc + dly;
                        e.lane = l;
                        e.exp = {ed, idl ? 4'h0 : kk, v, v & ~idl, stb & ~idl,
                                 idl ? 2'b00 : sh, idl};
                        sb.push_back(e);
                    end
                end
            end else begin
                TxDataValid = '0;
                TxElecIdle  = '1;
                ErrInject   = '0;
            end
            #1;
            for (int q = 0; q < sb.size(); ) begin
                if (sb[q].due == cyc) begin
                    e   = sb[q];
                    obs = {RxData[e.lane*W +: W], RxDataK[e.lane*KW +: KW], RxDataValid[e.lane],
                           RxValid[e.lane], RxStartBlock[e.lane], RxSyncHeader[2*e.lane +: 2],
                           RxElectricalIdle[e.lane]};
                    nChecks++;
                    if (obs !== e.exp) begin
                        nFails++;
                        $display("FAIL datapath lane=%0d cyc=%0d got=%h required=%h",
                                 e.lane, cyc, obs, e.exp);
                    end
                    sb.delete(q);
                end else begin
                    q++;
                end
            end
        end
        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("FAIL sb_drain left=%0d required 0", sb.size());
        end
    endtask

    task automatic test_rate_collision();
        logic [L-1:0] expPhy;
        nextCycle();
        nextCycle();
        Rate = 4'd1;
        TxDetectRx_Loopback = '1;
        for (int k = 1; k < 15; k++) begin
            nextCycle();
            #1;
            expPhy = (k == 6) ? 16'hFFFF : 16'h0000;
            nChecks++;
            if (PhyStatus !== expPhy || RxStatus !== '0) begin
                nFails++;
                $display("FAIL rate_collision k=%0d PhyStatus=%h RxStatus=%h required %h/0",
                         k, PhyStatus, RxStatus, expPhy);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        TxDetectRx_Loopback = '0;
        nextCycle();
        nextCycle();
        nextCycle();
        TxDetectRx_Loopback = '1;
        nextCycle();
        nextCycle();
        reset = 1'b1;
        nextCycle();
        for (int k = 0; k < 14; k++) begin
            nextCycle();
            reset = 1'b0;
            #1;
            nChecks++;
            if (PhyStatus !== ((k < 8) ? 16'hFFFF : 16'h0000) || RxStatus !== '0) begin
                nFails++;
                $display("FAIL reset_mid_wait k=%0d PhyStatus=%h RxStatus=%h required %h/0",
                         k, PhyStatus, RxStatus, (k < 8) ? 16'hFFFF : 16'h0000);
            end
        end
    endtask

    task automatic test_pending();
        logic [3*L-1:0] expSt;
        logic [L-1:0]   expPhy;
        logic [3*L-1:0] expRx;
        for (int l = 0; l < L; l++) expSt[3*l +: 3] = PRESENT[l] ? 3'b011 : 3'b000;
        TxDetectRx_Loopback = '0;
        nextCycle();
        nextCycle();
        nextCycle();
        TxDetectRx_Loopback = '1;
        for (int k = 1; k < 11; k++) begin
            nextCycle();
            if (k == 1) PowerDown[23:20] = 4'h2;
            #1;
            expPhy = (k == 4) ? 16'hFFFF : (k == 8) ? 16'h0020 : 16'h0000;
            expRx  = (k == 4) ? expSt : '0;
            nChecks++;
            if (PhyStatus !== expPhy || RxStatus !== expRx) begin
                nFails++;
                $display("FAIL pending_pd k=%0d PhyStatus=%h RxStatus=%h required %h/%h",
                         k, PhyStatus, RxStatus, expPhy, expRx);
            end
        end
    endtask

    initial begin
        reset               = 1'b1;
        TxData              = '0;
        TxDataValid         = '0;
        TxDataK             = '0;
        TxElecIdle          = '1;
        TxStartBlock        = '0;
        TxSyncHeader        = '0;
        TxDetectRx_Loopback = '0;
        PowerDown           = '0;
        Rate                = 4'd0;
        RxPresent           = PRESENT;
        LaneSkew            = '0;
        LaneSkew[3:2]       = 2'd3;
        LaneSkew[7:6]       = 2'd2;
        ErrInject           = '0;

        test_reset();
        test_detect();
        test_datapath();
        test_rate_collision();
        test_reset_mid_wait();
        test_pending();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
